reg_write_sequencer: RTL

Write-side initiator for the 8x16 register file. Execution units hand it results (destination index plus data) over a valid/ready handshake. It buffers them in a small FIFO and drives the register file's `dataSel`/`dataIn`/`load` write port with a clean setup-then-strobe sequence, because the register file captures on the rising edge of `load`. It also reports, for two read selects, whether a write to that register is still pending, so issue logic can stall on read-after-write hazards.

---
 rtl/reg_write_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - buffered setup-then-strobe write initiator for the 8x16 register file
// Optional WB_FORWARD_EN adds fwdData1/fwdData2 (newest pending data for each query select).
module reg_write_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [ADDR_W-1:0] inDest,
  input  logic [DATA_W-1:0] inData,
  output logic [ADDR_W-1:0] dataSel,
  output logic [DATA_W-1:0] dataIn,
  output logic              load,
  input  logic [ADDR_W-1:0] qSel1,
  input  logic [ADDR_W-1:0] qSel2,
  output logic              pending1,
  output logic              pending2,
`ifdef WB_FORWARD_EN
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
`endif
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] destMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign inReady = !full && !rst;
  assign push    = inValid && inReady;
  // Pops only happen where dataSel/dataIn may change: never on the edge load rises.
  assign pop     = !empty && (state == IDLE || state == STROBE);
  assign idle    = empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      destMem[tail] <= inDest;
      dataMem[tail] <= inData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dataSel <= '0;
      dataIn  <= '0;
      load    <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      case (state)
        IDLE: begin
          if (pop) begin
            dataSel <= destMem[head];
            dataIn  <= dataMem[head];
            state   <= SETUP;
          end
        end
        SETUP: begin
          load  <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          load <= 1'b0;
          if (pop) begin
            dataSel <= destMem[head];
            dataIn  <= dataMem[head];
            state   <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan oldest to newest so later matches override earlier ones; in-flight entry is oldest of all.
  always_comb begin
    idx      = '0;
    pending1 = (state != IDLE) && (dataSel == qSel1);
    pending2 = (state != IDLE) && (dataSel == qSel2);
`ifdef WB_FORWARD_EN
    fwdData1 = pending1 ? dataIn : '0;
    fwdData2 = pending2 ? dataIn : '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (destMem[idx] == qSel1) begin
          pending1 = 1'b1;
`ifdef WB_FORWARD_EN
          fwdData1 = dataMem[idx];
`endif
        end
        if (destMem[idx] == qSel2) begin
          pending2 = 1'b1;
`ifdef WB_FORWARD_EN
          fwdData2 = dataMem[idx];
`endif
        end
      end
    end
  end

endmodule
